// File: rtl/msi_bus_ctrl_pkg.sv
// Shared MSI definitions: bus message codes, cache line states and the
// snooping-bus controller FSM state type. Imported as msi_pkg.
package msi_pkg;

  localparam int BUS_MSG_W = 3;

  localparam logic [BUS_MSG_W-1:0] BUS_IDLE = 3'd0;
  localparam logic [BUS_MSG_W-1:0] BUS_RD   = 3'd1;
  localparam logic [BUS_MSG_W-1:0] BUS_RDX  = 3'd2;
  localparam logic [BUS_MSG_W-1:0] BUS_UPGR = 3'd3;

  localparam logic [1:0] INVALID  = 2'd0;
  localparam logic [1:0] SHARED   = 2'd1;
  localparam logic [1:0] MODIFIED = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_SNOOP = 3'd2,
    ST_MEM   = 3'd3,
    ST_RESP  = 3'd4
  } bus_state_e;

endpackage

// File: rtl/msi_bus_ctrl_if.sv
// Bus bundle between the MSI caches and the snooping-bus controller.
// slave = controller side, master = cache-array side.
interface msi_bus_ctrl_if #(
  parameter int NUM_CPUS = 2,
  parameter int ADDR_W   = 2
);

  localparam int SRC_W = $clog2(NUM_CPUS);

  logic [NUM_CPUS-1:0]                   req_i;
  logic [NUM_CPUS-1:0]                   gnt_o;
  logic [msi_pkg::BUS_MSG_W*NUM_CPUS-1:0] cpu_msg_i;
  logic [ADDR_W*NUM_CPUS-1:0]            cpu_addr_i;
  logic [msi_pkg::BUS_MSG_W-1:0]         bus_msg_o;
  logic [ADDR_W-1:0]                     bus_addr_o;
  logic [SRC_W-1:0]                      bus_src_o;
  logic [NUM_CPUS-1:0]                   flush_i;
  logic [NUM_CPUS-1:0]                   data_valid_o;
  logic                                  wb_o;
  logic                                  proto_err_o;

  modport slave (
    input  req_i, cpu_msg_i, cpu_addr_i, flush_i,
    output gnt_o, bus_msg_o, bus_addr_o, bus_src_o, data_valid_o, wb_o, proto_err_o
  );

  modport master (
    output req_i, cpu_msg_i, cpu_addr_i, flush_i,
    input  gnt_o, bus_msg_o, bus_addr_o, bus_src_o, data_valid_o, wb_o, proto_err_o
  );

endinterface

// File: rtl/msi_bus_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i,
// wrapping around. Returns one-hot grant, its index and a found flag.
module rr_arbiter #(
  parameter int NUM_CPUS = 2,
  localparam int IDX_W   = $clog2(NUM_CPUS)
) (
  input  logic [NUM_CPUS-1:0] req_i,
  input  logic [IDX_W-1:0]    ptr_i,
  output logic [NUM_CPUS-1:0] onehot_o,
  output logic [IDX_W-1:0]    idx_o,
  output logic                any_o
);

  // Scan from ptr upward with wrap; first hit wins.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    for (int i = 0; i < NUM_CPUS; i++) begin
      int j;
      j = int'(ptr_i) + i;
      if (j >= NUM_CPUS) j = j - NUM_CPUS;
      if (!any_o && req_i[j]) begin
        any_o       = 1'b1;
        idx_o       = IDX_W'(j);
        onehot_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/msi_bus_ctrl.sv
// Snooping-bus controller for the MSI system: round-robin arbitration,
// one-cycle snoop broadcast, data phase from a flushing cache or memory.
// Optional protocol checker enabled by `define MSI_BUS_PROTO_CHECK_EN.
module msi_bus_ctrl
  import msi_pkg::*;
#(
  parameter int NUM_CPUS = 2,
  parameter int ADDR_W   = 2,
  parameter int MEM_LAT  = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  msi_bus_ctrl_if.slave bus
);

  localparam int SRC_W = $clog2(NUM_CPUS);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  bus_state_e              state_q;
  logic [SRC_W-1:0]        ptr_q;
  logic [SRC_W-1:0]        src_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [NUM_CPUS-1:0]     gnt_q;
  logic [BUS_MSG_W-1:0]    bus_msg_q;
  logic [ADDR_W-1:0]       bus_addr_q;
  logic [NUM_CPUS-1:0]     dv_q;
  logic                    wb_q;

  logic [NUM_CPUS-1:0]     win_onehot;
  logic [SRC_W-1:0]        win_idx;
  logic                    win_any;
  logic [BUS_MSG_W-1:0]    sel_msg;
  logic [ADDR_W-1:0]       sel_addr;
  logic [NUM_CPUS-1:0]     flush_oth;

  rr_arbiter #(.NUM_CPUS(NUM_CPUS)) u_arb (
    .req_i    (bus.req_i),
    .ptr_i    (ptr_q),
    .onehot_o (win_onehot),
    .idx_o    (win_idx),
    .any_o    (win_any)
  );

  // Master's message/address muxed out of the packed per-cache buses;
  // gnt_q is the one-hot of src, so it doubles as the master mask.
  always_comb begin
    sel_msg   = bus.cpu_msg_i[BUS_MSG_W*int'(src_q) +: BUS_MSG_W];
    sel_addr  = bus.cpu_addr_i[ADDR_W*int'(src_q) +: ADDR_W];
    flush_oth = bus.flush_i & ~gnt_q;
  end

  // Transaction FSM with all bus outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      src_q      <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      bus_msg_q  <= BUS_IDLE;
      bus_addr_q <= '0;
      dv_q       <= '0;
      wb_q       <= 1'b0;
    end else begin
      dv_q      <= '0;
      wb_q      <= 1'b0;
      bus_msg_q <= BUS_IDLE;
      unique case (state_q)
        ST_IDLE: begin
          if (win_any) begin
            src_q   <= win_idx;
            gnt_q   <= win_onehot;
            ptr_q   <= (win_idx == SRC_W'(NUM_CPUS - 1)) ? '0 : win_idx + 1'b1;
            state_q <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (sel_msg == BUS_IDLE) begin
            gnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            bus_msg_q  <= sel_msg;
            bus_addr_q <= sel_addr;
            state_q    <= ST_SNOOP;
          end
        end
        ST_SNOOP: begin
          if (bus_msg_q == BUS_UPGR) begin
            dv_q    <= gnt_q;
            state_q <= ST_RESP;
          end else if (|flush_oth) begin
            dv_q    <= gnt_q;
            wb_q    <= 1'b1;
            state_q <= ST_RESP;
          end else begin
            cnt_q   <= CNT_W'(MEM_LAT - 1);
            state_q <= ST_MEM;
          end
        end
        ST_MEM: begin
          if (cnt_q == '0) begin
            dv_q    <= gnt_q;
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RESP: begin
          gnt_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt_o        = gnt_q;
  assign bus.bus_msg_o    = bus_msg_q;
  assign bus.bus_addr_o   = bus_addr_q;
  assign bus.bus_src_o    = src_q;
  assign bus.data_valid_o = dv_q;
  assign bus.wb_o         = wb_q;

`ifdef MSI_BUS_PROTO_CHECK_EN
  logic proto_err_q;
  logic proto_viol;

  // Violations visible during the snoop cycle.
  always_comb begin
    proto_viol = ((flush_oth & (flush_oth - 1'b1)) != '0) ||
                 (|(bus.flush_i & gnt_q)) ||
                 ((bus_msg_q == BUS_UPGR) && (|flush_oth)) ||
                 (bus_msg_q > BUS_UPGR);
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      proto_err_q <= 1'b0;
    end else if (state_q == ST_SNOOP && proto_viol) begin
      proto_err_q <= 1'b1;
    end
  end

  assign bus.proto_err_o = proto_err_q;
`else
  assign bus.proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_msi_bus_ctrl.sv
// Self-checking bench for msi_bus_ctrl (NUM_CPUS=2, ADDR_W=2, MEM_LAT=4).
`timescale 1ns/1ps
module tb_msi_bus_ctrl;
  import msi_pkg::*;

  localparam int N   = 2;
  localparam int AW  = 2;
  localparam int LAT = 4;

  typedef struct {
    logic [N-1:0] dv;
    logic         wb;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   gap, busy;
  exp_t sb[$];
  exp_t mon_e;
  logic [N-1:0] fair_exp [3] = '{2'b01, 2'b10, 2'b01};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  msi_bus_ctrl_if #(.NUM_CPUS(N), .ADDR_W(AW)) bus_if ();

  msi_bus_ctrl #(.NUM_CPUS(N), .ADDR_W(AW), .MEM_LAT(LAT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Scoreboard: every data_valid / wb pulse must match the next queued entry.
  always @(negedge clk) begin
    if (bus_if.data_valid_o != '0 || bus_if.wb_o) begin
      if (sb.size() == 0) begin
        check("dv_unexpected", 32'({bus_if.wb_o, bus_if.data_valid_o}), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("dv_vec", 32'(bus_if.data_valid_o), 32'(mon_e.dv));
        check("dv_wb", 32'(bus_if.wb_o), 32'(mon_e.wb));
        if (mon_e.cyc >= 0) check("dv_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic txn(input logic [N-1:0] req, input logic [3*N-1:0] msg,
                     input logic [AW*N-1:0] addr, input logic [N-1:0] flush,
                     input logic [N-1:0] exp_gnt, input int exp_src, input int lat,
                     input logic exp_wb, input logic [2:0] exp_msg,
                     input logic [AW-1:0] exp_addr, input logic exp_err);
    int c0;
    @(negedge clk);
    bus_if.req_i = req; bus_if.cpu_msg_i = msg; bus_if.cpu_addr_i = addr;
    c0 = cyc;
    if (lat > 0) sb.push_back('{dv: exp_gnt, wb: exp_wb, cyc: c0 + lat});
    @(negedge clk);
    bus_if.req_i = '0; bus_if.flush_i = flush;
    check("gnt_c1", 32'(bus_if.gnt_o), 32'(exp_gnt));
    check("src_c1", 32'(bus_if.bus_src_o), 32'(exp_src));
    check("busmsg_c1", 32'(bus_if.bus_msg_o), 32'(BUS_IDLE));
    @(negedge clk);
    if (lat == 0) begin
      check("gnt_abort", 32'(bus_if.gnt_o), 32'd0);
      check("busmsg_abort", 32'(bus_if.bus_msg_o), 32'(BUS_IDLE));
      bus_if.flush_i = '0;
    end else begin
      check("busmsg_c2", 32'(bus_if.bus_msg_o), 32'(exp_msg));
      check("busaddr_c2", 32'(bus_if.bus_addr_o), 32'(exp_addr));
      check("gnt_c2", 32'(bus_if.gnt_o), 32'(exp_gnt));
      @(negedge clk);
      bus_if.flush_i = '0;
      check("busmsg_c3", 32'(bus_if.bus_msg_o), 32'(BUS_IDLE));
      check("err_c3", 32'(bus_if.proto_err_o), 32'(exp_err));
      if (lat > 3) check("gnt_mem", 32'(bus_if.gnt_o), 32'(exp_gnt));
      for (int i = 0; i < 20 && bus_if.gnt_o != '0; i++) @(negedge clk);
      check("txn_done", 32'(bus_if.gnt_o), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus_if.req_i = '0; bus_if.cpu_msg_i = '0; bus_if.cpu_addr_i = '0; bus_if.flush_i = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(bus_if.gnt_o), 32'd0);
    check("rst_busmsg", 32'(bus_if.bus_msg_o), 32'd0);
    check("rst_busaddr", 32'(bus_if.bus_addr_o), 32'd0);
    check("rst_src", 32'(bus_if.bus_src_o), 32'd0);
    check("rst_dv", 32'(bus_if.data_valid_o), 32'd0);
    check("rst_wb", 32'(bus_if.wb_o), 32'd0);
    check("rst_err", 32'(bus_if.proto_err_o), 32'd0);
    rst = 1'b0;

    // memory path: cache 0 BUS_RD addr 2, data_valid at cycle 3+MEM_LAT
    txn(2'b01, 6'b000_001, 4'b00_10, 2'b00, 2'b01, 0, 3 + LAT, 1'b0, BUS_RD, 2'd2, 1'b0);
    // flush path: cache 1 BUS_RDX addr 1, cache 0 flushes
    txn(2'b10, 6'b010_000, 4'b01_00, 2'b01, 2'b10, 1, 3, 1'b1, BUS_RDX, 2'd1, 1'b0);
    // upgrade: cache 0, no memory phase
    txn(2'b01, 6'b000_011, 4'b00_11, 2'b00, 2'b01, 0, 3, 1'b0, BUS_UPGR, 2'd3, 1'b0);
    // abort: cache 1 granted but drives BUS_IDLE
    txn(2'b10, 6'b000_000, 4'b00_00, 2'b00, 2'b10, 1, 0, 1'b0, BUS_IDLE, 2'd0, 1'b0);

    // fairness: both request continuously, upgrades from both
    @(negedge clk);
    bus_if.cpu_msg_i = 6'b011_011; bus_if.cpu_addr_i = 4'b01_11; bus_if.req_i = 2'b11;
    for (int k = 0; k < 3; k++) sb.push_back('{dv: fair_exp[k], wb: 1'b0, cyc: -1});
    for (int k = 0; k < 3; k++) begin
      gap = 0;
      while (bus_if.gnt_o == '0 && gap < 20) begin @(negedge clk); gap++; end
      check("fair_gnt", 32'(bus_if.gnt_o), 32'(fair_exp[k]));
      if (k > 0) check("fair_gap", gap, 1);
      if (k == 2) bus_if.req_i = '0;
      busy = 0;
      while (bus_if.gnt_o != '0 && busy < 20) begin @(negedge clk); busy++; end
      check("fair_busy", busy, 3);
    end

    // reset during MEM: no data_valid, ptr back to 0
    @(negedge clk);
    bus_if.req_i = 2'b01; bus_if.cpu_msg_i = 6'b000_001; bus_if.cpu_addr_i = 4'b00_11;
    @(negedge clk);
    bus_if.req_i = '0;
    repeat (3) @(negedge clk);
    check("pre_rst_gnt", 32'(bus_if.gnt_o), 32'b01);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_gnt", 32'(bus_if.gnt_o), 32'd0);
    check("midrst_busaddr", 32'(bus_if.bus_addr_o), 32'd0);
    check("midrst_src", 32'(bus_if.bus_src_o), 32'd0);
    check("midrst_dv", 32'(bus_if.data_valid_o), 32'd0);
    check("midrst_wb", 32'(bus_if.wb_o), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    txn(2'b11, 6'b011_011, 4'b00_00, 2'b00, 2'b01, 0, 3, 1'b0, BUS_UPGR, 2'd0, 1'b0);

    // double flush during BUS_RD from cache 0 (master itself flushing)
`ifdef MSI_BUS_PROTO_CHECK_EN
    txn(2'b01, 6'b000_001, 4'b00_01, 2'b11, 2'b01, 0, 3, 1'b1, BUS_RD, 2'd1, 1'b1);
    repeat (3) @(negedge clk);
    check("err_sticky", 32'(bus_if.proto_err_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("err_rst", 32'(bus_if.proto_err_o), 32'd0);
    rst = 1'b0;
`else
    txn(2'b01, 6'b000_001, 4'b00_01, 2'b11, 2'b01, 0, 3, 1'b1, BUS_RD, 2'd1, 1'b0);
    repeat (3) @(negedge clk);
    check("err_tied", 32'(bus_if.proto_err_o), 32'd0);
`endif

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
